// File: rtl/output_buffer_ctrl_if.sv
// Handshake bundle between the layer sequencer, the ping-pong output buffer
// and the MAC array. The layer FSM side is master; the sequencer is slave.
interface output_buffer_ctrl_if #(
  parameter int PASS_W = 8,
  parameter int TILE_W = 10
);
  logic              start;
  logic [3:0]        CS;
  logic [PASS_W-1:0] cfg_passes;
  logic [TILE_W-1:0] cfg_tiles;
  logic              mac_ready;
  logic              result_33_vld;
  logic              store_ack;

  logic [3:0]        cs_lat;
  logic              output_buffer_initial;
  logic              buf_en;
  logic              store_en;
  logic              mac_issue;
  logic              store_req;
  logic              busy;
  logic              done;
  logic [PASS_W-1:0] pass_cnt;
  logic [TILE_W-1:0] tile_cnt;
  logic [1:0]        err;

  modport master (
    output start, CS, cfg_passes, cfg_tiles, mac_ready, result_33_vld, store_ack,
    input  cs_lat, output_buffer_initial, buf_en, store_en, mac_issue, store_req,
           busy, done, pass_cnt, tile_cnt, err
  );

  modport slave (
    input  start, CS, cfg_passes, cfg_tiles, mac_ready, result_33_vld, store_ack,
    output cs_lat, output_buffer_initial, buf_en, store_en, mac_issue, store_req,
           busy, done, pass_cnt, tile_cnt, err
  );
endinterface

// File: rtl/output_buffer_ctrl.sv
// Per-layer tile sequencer: bias-init both banks, run the accumulation passes,
// flag the final pass with store_en and hand each tile to the store path.
module output_buffer_ctrl #(
  parameter int PASS_W  = 8,
  parameter int TILE_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  output_buffer_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT0, S_INIT1, S_ISSUE, S_WAIT_RES, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t            state, state_d;
  logic [3:0]        cs_q, cs_d;
  logic [PASS_W-1:0] passes_q, passes_d, pass_q, pass_d;
  logic [TILE_W-1:0] tiles_q, tiles_d, tile_q, tile_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [1:0]        err_q, err_d;
  logic              last_pass;

  assign last_pass = (pass_q == passes_q - PASS_W'(1));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state;
    cs_d     = cs_q;
    passes_d = passes_q;
    tiles_d  = tiles_q;
    pass_d   = pass_q;
    tile_d   = tile_q;
    wd_d     = wd_q;
    err_d    = err_q;

    // A result strobe is only meaningful while a pass is outstanding.
    if (bus.result_33_vld && state != S_WAIT_RES) err_d[1] = 1'b1;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          cs_d     = bus.CS;
          passes_d = bus.cfg_passes;
          tiles_d  = bus.cfg_tiles;
          pass_d   = '0;
          tile_d   = '0;
          err_d    = {bus.result_33_vld, 1'b0};
          state_d  = (bus.cfg_passes == '0 || bus.cfg_tiles == '0) ? S_DONE : S_INIT0;
        end
      end
      S_INIT0: state_d = S_INIT1;
      S_INIT1: state_d = S_ISSUE;
      S_ISSUE: begin
        if (bus.mac_ready) begin
          wd_d    = '0;
          state_d = S_WAIT_RES;
        end
      end
      S_WAIT_RES: begin
        // A result landing on the expiry cycle still wins over the watchdog.
        if (bus.result_33_vld) begin
          if (last_pass) begin
            state_d = S_STORE;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_ISSUE;
          end
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d[0] = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_STORE: if (bus.store_ack) state_d = S_NEXT;
      S_NEXT: begin
        pass_d = '0;
        if (tile_q == tiles_q - TILE_W'(1)) begin
          state_d = S_DONE;
        end else begin
          tile_d  = tile_q + TILE_W'(1);
          state_d = S_INIT0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state, so they are aligned with the
  // state they describe and never follow an input combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                     <= S_IDLE;
      cs_q                      <= '0;
      passes_q                  <= '0;
      tiles_q                   <= '0;
      pass_q                    <= '0;
      tile_q                    <= '0;
      wd_q                      <= '0;
      err_q                     <= '0;
      bus.output_buffer_initial <= 1'b0;
      bus.buf_en                <= 1'b0;
      bus.store_en              <= 1'b0;
      bus.mac_issue             <= 1'b0;
      bus.store_req             <= 1'b0;
      bus.busy                  <= 1'b0;
      bus.done                  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state                     <= state_d;
      cs_q                      <= cs_d;
      passes_q                  <= passes_d;
      tiles_q                   <= tiles_d;
      pass_q                    <= pass_d;
      tile_q                    <= tile_d;
      wd_q                      <= wd_d;
      err_q                     <= err_d;
      bus.output_buffer_initial <= (state_d == S_INIT0);
      bus.buf_en                <= (state_d == S_ISSUE) || (state_d == S_WAIT_RES);
      bus.store_en              <= (state_d == S_WAIT_RES) && (pass_d == passes_d - PASS_W'(1));
      bus.mac_issue             <= (state_d == S_ISSUE);
      bus.store_req             <= (state_d == S_STORE);
      bus.busy                  <= (state_d != S_IDLE);
      bus.done                  <= (state_d == S_DONE);
    end
  end

  assign bus.cs_lat   = cs_q;
  assign bus.pass_cnt = pass_q;
  assign bus.tile_cnt = tile_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: reactive MAC/store responders, an issue/store
// scoreboard, a table of layer configurations and hand-written corner cases.
module tb_output_buffer_ctrl;
  localparam int PASS_W  = 8;
  localparam int TILE_W  = 10;
  localparam int TIMEOUT = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  output_buffer_ctrl_if #(.PASS_W(PASS_W), .TILE_W(TILE_W)) bus ();

  output_buffer_ctrl #(.PASS_W(PASS_W), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  typedef struct {
    int passes; int tiles; int cs; int res_lat;
    int exp_init; int exp_issue; int exp_store; int exp_done; int exp_sen; int exp_done_cyc;
  } vec_t;

  typedef struct { int tile; int pass; } issue_t;

  vec_t   vecs [6];
  issue_t issue_q [$];
  int     store_q [$];
  issue_t e_pop;

  // Responder controls (set by the main sequence, used by the responder).
  int res_lat = 2, res_cd = -1, stall_pass = -1, stall_left = 0;
  int cur_passes = 0, cur_pass_exp = 0;
  bit res_en = 1'b1, inject_init1 = 1'b0;
  bit init_prev, issue_prev, ready_prev, req_prev, vld_now, ready_now;

  // Event counters for the current layer.
  int n_init, n_issue, n_store, n_done, n_sen, n_wait, n_issue_p1;

  function automatic logic [63:0] out_vec();
    return {33'd0, bus.cs_lat, bus.output_buffer_initial, bus.buf_en, bus.store_en,
            bus.mac_issue, bus.store_req, bus.busy, bus.done,
            bus.pass_cnt, bus.tile_cnt, bus.err};
  endfunction

  // MAC array / store path model: samples at negedge, drives the next cycle's inputs.
  initial begin
    bus.mac_ready     = 1'b1;
    bus.result_33_vld = 1'b0;
    bus.store_ack     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        res_cd = -1; bus.result_33_vld = 1'b0; bus.store_ack = 1'b0; bus.mac_ready = 1'b1;
        init_prev = 1'b0; issue_prev = 1'b0; ready_prev = 1'b1; req_prev = 1'b0;
      end else begin
        if (bus.output_buffer_initial) n_init++;
        if (bus.done) n_done++;
        if (bus.mac_issue && bus.pass_cnt == 1 && bus.tile_cnt == 0) n_issue_p1++;
        if (issue_prev && ready_prev) begin
          n_issue++;
          res_cd = res_lat;
          if (issue_q.size() == 0) check("unexpected_issue", 1, 0);
          else begin
            e_pop = issue_q.pop_front();
            cur_pass_exp = e_pop.pass;
            check("issue_tile", bus.tile_cnt, e_pop.tile);
            check("issue_pass", bus.pass_cnt, e_pop.pass);
          end
        end
        if (req_prev && !bus.store_req) begin
          n_store++;
          if (store_q.size() == 0) check("unexpected_store", 1, 0);
          else check("store_tile", bus.tile_cnt, store_q.pop_front());
        end
        vld_now = 1'b0;
        if (res_cd > 0) begin
          res_cd--;
          if (res_cd == 0) begin vld_now = res_en; res_cd = -1; end
        end
        if (inject_init1 && init_prev && !bus.output_buffer_initial && bus.busy) begin
          vld_now = 1'b1;
          inject_init1 = 1'b0;
        end
        if (bus.buf_en && !bus.mac_issue) begin
          n_wait++;
          check("store_en", bus.store_en, (cur_pass_exp == cur_passes - 1));
          if (vld_now && bus.store_en) n_sen++;
        end else if (bus.store_en) begin
          check("store_en_outside_wait", 1, 0);
        end
        ready_now = 1'b1;
        if (bus.mac_issue && bus.pass_cnt == stall_pass && stall_left > 0) begin
          ready_now = 1'b0;
          stall_left--;
        end
        bus.result_33_vld = vld_now;
        bus.store_ack     = bus.store_req && req_prev;
        bus.mac_ready     = ready_now;
        init_prev  = bus.output_buffer_initial;
        issue_prev = bus.mac_issue;
        ready_prev = ready_now;
        req_prev   = bus.store_req;
      end
    end
  end

  task automatic push_expected(input int passes, input int tiles);
    issue_t e;
    for (int t = 0; t < tiles && passes > 0; t++) begin
      for (int p = 0; p < passes; p++) begin
        e.tile = t; e.pass = p;
        issue_q.push_back(e);
      end
      store_q.push_back(t);
    end
  endtask

  task automatic start_layer(input vec_t v);
    n_init = 0; n_issue = 0; n_store = 0; n_done = 0; n_sen = 0; n_wait = 0; n_issue_p1 = 0;
    cur_passes = v.passes;
    res_lat    = v.res_lat;
    push_expected(v.passes, v.tiles);
    @(negedge clk);
    bus.CS         = 4'(v.cs);
    bus.cfg_passes = PASS_W'(v.passes);
    bus.cfg_tiles  = TILE_W'(v.tiles);
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic run_layer(input vec_t v, output int done_cyc);
    bit ended = 1'b0;
    start_layer(v);
    done_cyc = -1;
    for (int c = 1; c <= 3000 && !ended; c++) begin
      if (bus.done) begin done_cyc = c; ended = 1'b1; end
      else if (!bus.busy) ended = 1'b1;
      else @(negedge clk);
    end
    if (!ended) check("layer_cycle_budget", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  vec_t v;
  int   dc;

  initial begin
    bus.start = 1'b0; bus.CS = '0; bus.cfg_passes = '0; bus.cfg_tiles = '0;
    //           passes tiles cs  lat  init issue store done sen done_cyc
    vecs[0] = '{3,      2,    10, 2,   2,   6,    2,    1,   2,  -1};
    vecs[1] = '{1,      3,    3,  1,   3,   3,    3,    1,   3,  -1};
    vecs[2] = '{0,      2,    7,  2,   0,   0,    0,    1,   0,   1};
    vecs[3] = '{2,      0,    1,  2,   0,   0,    0,    1,   0,   1};
    vecs[4] = '{4,      1,    15, 4,   1,   4,    1,    1,   1,  -1};
    vecs[5] = '{1,      1,    6,  255, 1,   1,    1,    1,   1,  -1};

    #1 check("reset_outputs", out_vec(), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", bus.busy, 0);

    foreach (vecs[i]) begin
      run_layer(vecs[i], dc);
      check($sformatf("v%0d_init", i),  n_init,  vecs[i].exp_init);
      check($sformatf("v%0d_issue", i), n_issue, vecs[i].exp_issue);
      check($sformatf("v%0d_store", i), n_store, vecs[i].exp_store);
      check($sformatf("v%0d_done", i),  n_done,  vecs[i].exp_done);
      check($sformatf("v%0d_sen", i),   n_sen,   vecs[i].exp_sen);
      check($sformatf("v%0d_err", i),   bus.err, 0);
      check($sformatf("v%0d_cs", i),    bus.cs_lat, vecs[i].cs);
      check($sformatf("v%0d_busy", i),  bus.busy, 0);
      check($sformatf("v%0d_sb", i),    issue_q.size() + store_q.size(), 0);
      if (vecs[i].exp_done_cyc >= 0)
        check($sformatf("v%0d_done_lat", i), dc, vecs[i].exp_done_cyc);
    end

    // mac_ready withheld for 5 cycles on pass 1.
    stall_pass = 1; stall_left = 5;
    v = '{3, 1, 2, 2, 1, 3, 1, 1, 1, -1};
    run_layer(v, dc);
    check("stall_issue_hold", n_issue_p1, 6);
    check("stall_issue_count", n_issue, 3);
    check("stall_done", n_done, 1);
    stall_pass = -1;

    // No result returned: watchdog fires after TIMEOUT waiting cycles.
    res_en = 1'b0;
    v = '{2, 1, 4, 2, 1, 1, 0, 0, 0, -1};
    run_layer(v, dc);
    check("timeout_err", bus.err, 1);
    check("timeout_busy", bus.busy, 0);
    check("timeout_no_done", n_done, 0);
    check("timeout_wait_cycles", n_wait, TIMEOUT);
    check("timeout_no_store", n_store, 0);
    res_en = 1'b1;
    issue_q.delete(); store_q.delete();

    // Stray result during INIT1 of tile 0.
    inject_init1 = 1'b1;
    v = '{2, 2, 9, 2, 2, 4, 2, 1, 2, -1};
    run_layer(v, dc);
    check("stray_err", bus.err, 2);
    check("stray_issue", n_issue, 4);
    check("stray_store", n_store, 2);
    check("stray_done", n_done, 1);
    check("stray_sb", issue_q.size() + store_q.size(), 0);

    // Reset during WAIT_RES of tile 0, pass 2, then a fresh layer.
    start_layer(vecs[0]);
    begin
      bit hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
        if (bus.buf_en && !bus.mac_issue && bus.pass_cnt == 2 && bus.tile_cnt == 0) hit = 1'b1;
        else @(negedge clk);
      end
      check("reach_pass2_wait", hit, 1);
    end
    #2 rst = 1'b0;
    #1 check("midreset_outputs", out_vec(), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("midreset_idle", bus.busy, 0);
    check("midreset_no_done", n_done, 0);
    issue_q.delete(); store_q.delete();
    run_layer(vecs[0], dc);
    check("rerun_issue", n_issue, 6);
    check("rerun_store", n_store, 2);
    check("rerun_done", n_done, 1);
    check("rerun_err", bus.err, 0);
    check("rerun_sb", issue_q.size() + store_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end
endmodule
